sipo_deser: RTL and testbench

//   Serial-in/parallel-out deserializer: receiving end of the piso serial link.

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_out_buf.sv | 68 ++++++
 rtl/sipo_deser.sv | 136 +++++++++++++
 tb/tb_sipo_deser.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel receiver.
// The PARITY state is only reached when SIPO_PARITY_EN is defined.
package sipo_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words, with overrun flagging.
// SIPO_PARITY_EN adds a parity-error flag that travels with the buffered word.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
`ifdef SIPO_PARITY_EN
  input  logic             i_par_err,
  output logic             o_par_err,
`endif
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;
  logic             w_space;

  // A word can land when the slot is empty or is being drained this same cycle.
  assign w_space = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        if (w_space) begin
          r_word  <= i_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (i_load && w_space) begin
      r_par_err <= i_par_err;
    end
  end

  assign o_par_err = r_par_err;
`endif

  assign o_word    = r_word;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer, MSB first, feeding a 1-entry output buffer.
// Optional trailing even-parity bit enabled by defining SIPO_PARITY_EN.
//
//   state  | meaning
//   IDLE   | waiting for a start-qualified bit
//   SHIFT  | collecting data bits, r_cnt = bits received so far
//   PARITY | all data bits held in r_shreg, waiting for the parity bit
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             start,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
`ifdef SIPO_PARITY_EN
  output logic             par_err,
`endif
  output logic             overrun
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [WIDTH-1:0] w_shift_in;
  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_bit0;
  logic             w_last;
  logic             w_par_err;

  assign w_shift_in = {r_shreg[WIDTH-2:0], sin};
  assign w_bit0     = sin_en && start;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_done      = 1'b0;
    w_word      = w_shift_in;
    w_par_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_bit0) begin
          w_shreg_nxt = w_shift_in;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_bit0) begin
          // start mid-word abandons the partial word
          w_shreg_nxt = w_shift_in;
          w_cnt_nxt   = CNT_W'(1);
        end else if (sin_en) begin
          w_shreg_nxt = w_shift_in;
          if (w_last) begin
            w_cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_done      = 1'b1;
            w_state_nxt = IDLE;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (w_bit0) begin
          w_shreg_nxt = w_shift_in;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SHIFT;
        end else if (sin_en) begin
          w_done      = 1'b1;
          w_word      = r_shreg;
          w_par_err   = ^{r_shreg, sin};
          w_state_nxt = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_done),
    .i_word   (w_word),
`ifdef SIPO_PARITY_EN
    .i_par_err(w_par_err),
    .o_par_err(par_err),
`endif
    .i_ready  (po_ready),
    .o_word   (po),
    .o_valid  (po_valid),
    .o_overrun(overrun)
  );

`ifndef SIPO_PARITY_EN
  logic w_unused;
  assign w_unused = w_par_err;
`endif

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=4); parity scenarios build with SIPO_PARITY_EN.
module tb_sipo_deser;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             sin;
  logic             sin_en;
  logic             start;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             busy;
  logic             overrun;
`ifdef SIPO_PARITY_EN
  logic             par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q_exp[$];
`ifdef SIPO_PARITY_EN
  logic             q_perr[$];
`endif

  sipo_deser #(
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sin     (sin),
    .sin_en  (sin_en),
    .start   (start),
    .po      (po),
    .po_valid(po_valid),
    .po_ready(po_ready),
    .busy    (busy),
`ifdef SIPO_PARITY_EN
    .par_err (par_err),
`endif
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedge, DUT captures on the posedge in between.
  task automatic send_bit(input logic b, input logic st);
    sin    = b;
    sin_en = 1'b1;
    start  = st;
    @(negedge clk);
    sin    = 1'b0;
    sin_en = 1'b0;
    start  = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i], i == WIDTH - 1);
      if (i != 0) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain_one();
    po_ready = 1'b1;
    @(negedge clk);
    po_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 1'b0; sin_en = 1'b0; start = 1'b0; po_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (po !== 4'b0000) begin n_fail++; $display("FAIL reset_po got=%b exp=%b", po, 4'b0000); end
    n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", po_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] exp;
    q_exp.push_back(4'b1101);
    send_bit(1'b1, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    exp = q_exp.pop_front();
    n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", po_valid); end
    n_checks++; if (po !== exp) begin n_fail++; $display("FAIL basic_po got=%b exp=%b", po, exp); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got=%b exp=0", busy); end
    drain_one();
    n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", po_valid); end
    n_checks++; if (po !== exp) begin n_fail++; $display("FAIL basic_po_hold got=%b exp=%b", po, exp); end
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] exp;
    q_exp.push_back(4'b1010);
    send_bit(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    send_bit(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send_bit(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (po_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL gaps_midword valid=%b busy=%b exp valid=0 busy=1", po_valid, busy);
    end
    send_bit(1'b0, 1'b0);
    exp = q_exp.pop_front();
    n_checks++; if (po_valid !== 1'b1 || po !== exp) begin
      n_fail++; $display("FAIL gaps_po valid=%b po=%b exp valid=1 po=%b", po_valid, po, exp);
    end
    drain_one();
  endtask

  task automatic test_overrun();
    logic [WIDTH-1:0] exp;
    po_ready = 1'b0;
    q_exp.push_back(4'b1101);
    send_word(4'b1101, 0);
    send_word(4'b0110, 0);
    exp = q_exp.pop_front();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
    n_checks++; if (po !== exp || po_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_po_kept po=%b valid=%b exp po=%b valid=1", po, po_valid, exp);
    end
    @(negedge clk);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got=%b exp=0", overrun); end
    n_checks++; if (po !== exp) begin n_fail++; $display("FAIL ovr_po_stable got=%b exp=%b", po, exp); end
    drain_one();
  endtask

  task automatic test_accept_same_cycle();
    logic [WIDTH-1:0] exp;
    po_ready = 1'b0;
    send_word(4'b1101, 0);
    q_exp.push_back(4'b0110);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    po_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    po_ready = 1'b0;
    exp = q_exp.pop_front();
    n_checks++; if (po !== exp) begin n_fail++; $display("FAIL same_cycle_po got=%b exp=%b", po, exp); end
    n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL same_cycle_valid got=%b exp=1", po_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL same_cycle_overrun got=%b exp=0", overrun); end
    drain_one();
    n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_drain got=%b exp=0", po_valid); end
  endtask

  task automatic test_restart();
    logic [WIDTH-1:0] exp;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    q_exp.push_back(4'b0011);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL restart_early got=%b exp=0", po_valid); end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    exp = q_exp.pop_front();
    n_checks++; if (po_valid !== 1'b1 || po !== exp) begin
      n_fail++; $display("FAIL restart_po valid=%b po=%b exp valid=1 po=%b", po_valid, po, exp);
    end
    drain_one();
  endtask

  task automatic test_rst_mid();
    logic [WIDTH-1:0] exp;
    po_ready = 1'b0;
    send_word(4'b1010, 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (po !== 4'b0000 || po_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid po=%b valid=%b busy=%b ovr=%b exp all 0", po, po_valid, busy, overrun);
    end
    q_exp.push_back(4'b0111);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_cleared got=%b exp=0", po_valid); end
    send_bit(1'b1, 1'b0);
    exp = q_exp.pop_front();
    n_checks++; if (po_valid !== 1'b1 || po !== exp) begin
      n_fail++; $display("FAIL rst_after_word valid=%b po=%b exp valid=1 po=%b", po_valid, po, exp);
    end
    drain_one();
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] exp;
    logic             exp_perr;
    logic [1:0]       par_bits;
    par_bits = 2'b01;
    for (int k = 1; k >= 0; k--) begin
      q_exp.push_back(4'b1101);
      q_perr.push_back(^{4'b1101, par_bits[k]});
      send_word(4'b1101, 0);
      n_checks++; if (po_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL par_wait valid=%b busy=%b exp valid=0 busy=1", po_valid, busy);
      end
      send_bit(par_bits[k], 1'b0);
      exp      = q_exp.pop_front();
      exp_perr = q_perr.pop_front();
      n_checks++; if (po_valid !== 1'b1 || po !== exp) begin
        n_fail++; $display("FAIL par_po valid=%b po=%b exp valid=1 po=%b", po_valid, po, exp);
      end
      n_checks++; if (par_err !== exp_perr) begin
        n_fail++; $display("FAIL par_err got=%b exp=%b", par_err, exp_perr);
      end
      drain_one();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_accept_same_cycle();
    test_restart();
    test_rst_mid();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    n_checks++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", q_exp.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
